up_data_frame_buf: RTL

Parametrised single-clock frame buffer for upstream UART data: a byte stream is written with end-of-frame marks, and whole frames are read out. It is built on an inferred dual-port RAM (one write port, one read port) plus a frame-length FIFO. It generalises the fixed 8x4096 upstream dual-port RAM with these additions:
- configurable width and depth;
- frame commit and abort;
- overflow drop;
- read-side frame boundaries.

---
 rtl/up_data_frame_buf.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/up_data_frame_buf.sv
// Upstream frame buffer: byte RAM plus committed-frame length FIFO.
// Optional: define UP_FRM_BUF_STAT_EN for commit/drop statistics ports.
module up_data_frame_buf #(
  parameter int DW = 8,
  parameter int AW = 12,
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_eop,
  input  logic          wr_abort,
  output logic          wr_ready,
  output logic          rd_frm_valid,
  output logic [AW:0]   rd_frm_len,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_data_vld,
  output logic          rd_eop,
  output logic          drop_pulse
`ifdef UP_FRM_BUF_STAT_EN
  ,
  output logic [15:0]   stat_frm_in,
  output logic [15:0]   stat_frm_drop
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam int FD = 1 << FW;
  localparam logic [AW:0] P_ONE = (AW+1)'(1);
  localparam logic [AW:0] P_DEPTH = (AW+1)'(DEPTH);
  localparam logic [FW:0] F_ONE = (FW+1)'(1);
  localparam logic [FW:0] F_DEPTH = (FW+1)'(FD);

  logic [DW-1:0] ram [DEPTH];
  logic [AW:0]   lfifo [FD];

  logic [AW:0]   wp_cur;
  logic [AW:0]   wp_cmt;
  logic [AW:0]   rp;
  logic [AW:0]   used;
  logic [AW:0]   wr_len;
  logic [AW:0]   rd_cnt;
  logic          bad;
  logic [FW-1:0] lf_wp;
  logic [FW-1:0] lf_rp;
  logic [FW:0]   lf_cnt;

  logic rd_go;
  logic rd_last;
  logic wr_go;
  logic eop_ev;
  logic ovf;
  logic lf_full;
  logic commit;
  logic drop;

  // Handshake and commit/drop decisions for the current cycle.
  always_comb begin
    used         = wp_cur - rp;
    wr_ready     = (used != P_DEPTH);
    rd_frm_valid = (lf_cnt != '0);
    rd_frm_len   = rd_frm_valid ? lfifo[lf_rp] : '0;
    rd_go        = rd_en && rd_frm_valid;
    rd_last      = rd_go && ((rd_cnt + P_ONE) == rd_frm_len);
    wr_go        = wr_en && !wr_abort && wr_ready && !bad;
    eop_ev       = wr_en && wr_eop && !wr_abort;
    ovf          = wr_en && !wr_abort && !wr_ready;
    // A same-cycle pop frees a length slot for the pushing commit.
    lf_full      = (lf_cnt == F_DEPTH) && !rd_last;
    commit       = eop_ev && wr_go && !lf_full;
    drop         = eop_ev && !commit;
  end

  // Write/read pointers, frame state and length-FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_cur     <= '0;
      wp_cmt     <= '0;
      rp         <= '0;
      wr_len     <= '0;
      rd_cnt     <= '0;
      bad        <= 1'b0;
      lf_wp      <= '0;
      lf_rp      <= '0;
      lf_cnt     <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (wr_abort || drop) begin
        wp_cur <= wp_cmt;
        wr_len <= '0;
        bad    <= 1'b0;
      end else if (commit) begin
        wp_cur <= wp_cur + P_ONE;
        wp_cmt <= wp_cur + P_ONE;
        wr_len <= '0;
      end else begin
        if (wr_go) begin
          wp_cur <= wp_cur + P_ONE;
          wr_len <= wr_len + P_ONE;
        end
        if (ovf) bad <= 1'b1;
      end
      if (rd_go) begin
        rp     <= rp + P_ONE;
        rd_cnt <= rd_last ? '0 : rd_cnt + P_ONE;
      end
      if (commit) lf_wp <= lf_wp + 1'b1;
      if (rd_last) lf_rp <= lf_rp + 1'b1;
      unique case ({commit, rd_last})
        2'b10:   lf_cnt <= lf_cnt + F_ONE;
        2'b01:   lf_cnt <= lf_cnt - F_ONE;
        default: lf_cnt <= lf_cnt;
      endcase
    end
  end

  // Length FIFO storage; the pushed length includes the eop word.
  always_ff @(posedge clk) begin
    if (commit) lfifo[lf_wp] <= wr_len + P_ONE;
  end

  // Data RAM write port.
  always_ff @(posedge clk) begin
    if (wr_go) ram[wp_cur[AW-1:0]] <= wr_data;
  end

  // Registered RAM read port with frame-end flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data     <= '0;
      rd_data_vld <= 1'b0;
      rd_eop      <= 1'b0;
    end else begin
      rd_data_vld <= rd_go;
      rd_eop      <= rd_last;
      if (rd_go) rd_data <= ram[rp[AW-1:0]];
    end
  end

`ifdef UP_FRM_BUF_STAT_EN
  // Saturating commit and overflow-drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frm_in   <= '0;
      stat_frm_drop <= '0;
    end else begin
      if (commit && stat_frm_in != 16'hFFFF)
        stat_frm_in <= stat_frm_in + 16'd1;
      if (drop && stat_frm_drop != 16'hFFFF)
        stat_frm_drop <= stat_frm_drop + 16'd1;
    end
  end
`endif

endmodule
